// File: rtl/priority_encoder_hs_if.sv
// Request/index handshake bundle between a priority_encoder_hs and its producer/consumer.
// The encoder side (master) drives the registered index stream; the other side drives req/ready.
interface priority_encoder_hs_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic [N-1:0] req;
  logic         ready_in;
  logic         valid_out;
  logic [W-1:0] idx_out;
  logic         multi_out;
  logic         drop_out;

  modport master (
    input  req,
    input  ready_in,
    output valid_out,
    output idx_out,
    output multi_out,
    output drop_out
  );

  modport slave (
    output req,
    output ready_in,
    input  valid_out,
    input  idx_out,
    input  multi_out,
    input  drop_out
  );
endinterface

// File: rtl/priority_encoder_hs.sv
// Registered priority encoder: collects request lines into a sticky pending set and
// hands their indices out one per handshake, highest index first.
//
// state | meaning
// IDLE  | nothing presented; loads an entry as soon as pending is non-zero
// BUSY  | entry presented on idx_out/multi_out, waiting for ready_in
module priority_encoder_hs #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_hs_if.master bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] idx_q, idx_d;
  logic         multi_q, multi_d;
  logic         drop_q, drop_d;

  logic [N-1:0] req;
  logic         hs;
  logic [N-1:0] clr;
  logic [N-1:0] rem;

  function automatic logic [W-1:0] msb_idx(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) r = W'(k);
    end
    return r;
  endfunction

  // more than one bit set <=> clearing the lowest set bit leaves something behind
  function automatic logic more_than_one(input logic [N-1:0] v);
    return |(v & (v - N'(1)));
  endfunction

  assign req = bus.req;
  assign hs  = (state_q == BUSY) && bus.ready_in;
  assign clr = hs ? (N'(1) << idx_q) : '0;
  assign rem = pending_q & ~clr;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    multi_d   = multi_q;
    pending_d = rem | req;
    drop_d    = |(req & rem);
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          idx_d   = msb_idx(pending_q);
          multi_d = more_than_one(pending_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // requests arriving in the handshake cycle wait for the next selection
        if (hs) begin
          if (|rem) begin
            idx_d   = msb_idx(rem);
            multi_d = more_than_one(rem);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      multi_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.valid_out = (state_q == BUSY);
  assign bus.idx_out   = idx_q;
  assign bus.multi_out = multi_q;
  assign bus.drop_out  = drop_q;

endmodule

// File: tb/tb_priority_encoder_hs.sv
// Bench for priority_encoder_hs: per-cycle vector table on a 4-line instance with an
// entry scoreboard on the handshake, plus a hand-written sequence on an 8-line instance.
module tb_priority_encoder_hs;

  logic clk;
  logic rst;

  priority_encoder_hs_if #(.N(4), .W(2)) if4 ();
  priority_encoder_hs_if #(.N(8), .W(3)) if8 ();

  priority_encoder_hs #(.N(4), .W(2)) dut4 (.clk(clk), .rst(rst), .bus(if4.master));
  priority_encoder_hs #(.N(8), .W(3)) dut8 (.clk(clk), .rst(rst), .bus(if8.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       v;
    logic [1:0] idx;
    logic       m;
    logic       d;
    logic       chk_im;
  } vec_t;

  typedef struct {
    logic [1:0] idx;
    logic       m;
  } entry_t;

  vec_t   vecs[$];
  entry_t sb[$];

  function automatic void add_row(logic r, logic [3:0] rq, logic rdy,
                                  logic v, logic [1:0] i, logic m, logic d, logic ci);
    vec_t x;
    x.rst = r; x.req = rq; x.ready = rdy;
    x.v = v; x.idx = i; x.m = m; x.d = d; x.chk_im = ci;
    vecs.push_back(x);
  endfunction

  function automatic void expect_entry(logic [1:0] i, logic m);
    entry_t e;
    e.idx = i; e.m = m;
    sb.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every accepted entry on the 4-line instance must match the next expected one
  always @(negedge clk) begin
    if (rst === 1'b0 && if4.valid_out === 1'b1 && if4.ready_in === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_entry", {30'd0, if4.idx_out}, 32'hffff_ffff);
      end else begin
        entry_t e;
        e = sb.pop_front();
        chk("sb_idx", {30'd0, if4.idx_out}, {30'd0, e.idx});
        chk("sb_multi", {31'd0, if4.multi_out}, {31'd0, e.m});
      end
    end
  end

  initial begin
    rst = 1'b1;
    if4.req = '0; if4.ready_in = 1'b0;
    if8.req = '0; if8.ready_in = 1'b0;

    // rst  req      rdy   v  idx m  d  chk_im
    add_row(1, 4'b0000, 0,  0, 0, 0, 0, 1);
    add_row(1, 4'b0000, 0,  0, 0, 0, 0, 1);
    // single request, consumer always ready
    add_row(0, 4'b0100, 1,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  1, 2, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    expect_entry(2, 0);
    // two requests, held off by ready_in=0
    add_row(0, 4'b1010, 0,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 0,  1, 3, 1, 0, 1);
    add_row(0, 4'b0000, 0,  1, 3, 1, 0, 1);
    add_row(0, 4'b0000, 0,  1, 3, 1, 0, 1);
    add_row(0, 4'b0000, 1,  1, 1, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    expect_entry(3, 1); expect_entry(1, 0);
    // request held for three edges merges into one entry, drop pulses twice
    add_row(0, 4'b0001, 0,  0, 0, 0, 0, 0);
    add_row(0, 4'b0001, 0,  1, 0, 0, 1, 1);
    add_row(0, 4'b0001, 0,  1, 0, 0, 1, 1);
    add_row(0, 4'b0000, 0,  1, 0, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    expect_entry(0, 0);
    // request colliding with the clear of its own bit: no drop, re-emitted via IDLE
    add_row(0, 4'b0001, 0,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 0,  1, 0, 0, 0, 1);
    add_row(0, 4'b0001, 1,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  1, 0, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    expect_entry(0, 0); expect_entry(0, 0);
    // reset mid-handshake discards pending and the same-cycle request
    add_row(0, 4'b0110, 0,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 0,  1, 2, 1, 0, 1);
    add_row(1, 4'b1000, 1,  0, 0, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 1);
    // all four lines drain back-to-back, highest first
    add_row(0, 4'b1111, 1,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  1, 3, 1, 0, 1);
    add_row(0, 4'b0000, 1,  1, 2, 1, 0, 1);
    add_row(0, 4'b0000, 1,  1, 1, 1, 0, 1);
    add_row(0, 4'b0000, 1,  1, 0, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    expect_entry(3, 1); expect_entry(2, 1); expect_entry(1, 1); expect_entry(0, 0);
    // new request arriving on the final handshake is served after a pass through IDLE
    add_row(0, 4'b0001, 0,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  1, 0, 0, 0, 1);
    add_row(0, 4'b0100, 1,  0, 0, 0, 0, 0);
    add_row(0, 4'b0000, 1,  1, 2, 0, 0, 1);
    add_row(0, 4'b0000, 1,  0, 0, 0, 0, 0);
    expect_entry(0, 0); expect_entry(2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst          = vecs[i].rst;
      if4.req      = vecs[i].req;
      if4.ready_in = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), {31'd0, if4.valid_out}, {31'd0, vecs[i].v});
      chk($sformatf("row%0d_drop", i), {31'd0, if4.drop_out}, {31'd0, vecs[i].d});
      if (vecs[i].chk_im) begin
        chk($sformatf("row%0d_idx", i), {30'd0, if4.idx_out}, {30'd0, vecs[i].idx});
        chk($sformatf("row%0d_multi", i), {31'd0, if4.multi_out}, {31'd0, vecs[i].m});
      end
    end
    if4.req = '0; if4.ready_in = 1'b0;

    // 8-line instance: lines 7 and 0 together
    rst = 1'b0;
    if8.req = 8'h81; if8.ready_in = 1'b1;
    @(posedge clk); #1;
    chk("n8_valid0", {31'd0, if8.valid_out}, 32'd0);
    if8.req = 8'h00;
    @(posedge clk); #1;
    chk("n8_valid1", {31'd0, if8.valid_out}, 32'd1);
    chk("n8_idx1", {29'd0, if8.idx_out}, 32'd7);
    chk("n8_multi1", {31'd0, if8.multi_out}, 32'd1);
    @(posedge clk); #1;
    chk("n8_valid2", {31'd0, if8.valid_out}, 32'd1);
    chk("n8_idx2", {29'd0, if8.idx_out}, 32'd0);
    chk("n8_multi2", {31'd0, if8.multi_out}, 32'd0);
    @(posedge clk); #1;
    chk("n8_valid3", {31'd0, if8.valid_out}, 32'd0);
    chk("n8_drop3", {31'd0, if8.drop_out}, 32'd0);
    if8.ready_in = 1'b0;

    @(posedge clk); #1;
    chk("sb_leftover_entries", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
